speaker_arbiter: RTL and testbench

//  Shares one square-wave speaker output between NREQ sound sources (siren, alarm, melody).

---
 rtl/speaker_pkg.sv | 23 ++
 rtl/tone_divider.sv | 57 +++++
 rtl/speaker_arbiter.sv | 138 +++++++++++++
 tb/tb_speaker_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/speaker_pkg.sv
// Shared definitions for the speaker arbiter: FSM state encoding, default divider
// width and the fixed-priority encoder used to pick the next owner.
package speaker_pkg;

  localparam int DIV_W_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Lowest set index wins; callers zero-extend narrower request vectors to 8 bits.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period reload counter driving the speaker flop. The counter is loaded on the
// first enabled cycle and reloaded from the live divider at each toggle.
module tone_divider
  import speaker_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             speaker
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             spk_q, spk_d;
  logic             active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    spk_d    = spk_q;
    active_d = active_q;
    if (!en) begin
      cnt_d    = '0;
      spk_d    = 1'b0;
      active_d = 1'b0;
    end else if (div == '0) begin
      // A zero divider mutes the tone; the next nonzero value toggles straight away.
      cnt_d    = '0;
      spk_d    = 1'b0;
      active_d = 1'b1;
    end else if (!active_q) begin
      cnt_d    = div;
      active_d = 1'b1;
    end else if (cnt_q == '0) begin
      spk_d = ~spk_q;
      cnt_d = div;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      spk_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      spk_q    <= spk_d;
      active_q <= active_d;
    end
  end

  assign speaker = spk_q;

endmodule

// File: rtl/speaker_arbiter.sv
// Fixed-priority owner selection for a shared speaker with a minimum hold time before
// preemption and a silent gap between owners.
module speaker_arbiter
  import speaker_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int MIN_HOLD = 65536,
  parameter int GAP_CYC  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DIV_W-1:0] div,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  speaker
);

  localparam int OWN_W  = $clog2(NREQ);
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);

  state_e            state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;

  logic [7:0]        req_ext;
  logic [OWN_W-1:0]  first_req;
  logic              higher_req;
  logic              hold_sat;
  logic              gap_end;
  logic [DIV_W-1:0]  div_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_div
    assign div_arr[i] = div[i*DIV_W +: DIV_W];
  end

  always_comb begin
    req_ext = '0;
    req_ext[NREQ-1:0] = req;
  end

  assign first_req = OWN_W'(lowest_set(req_ext));
  assign hold_sat  = (hold_cnt_q == HOLD_W'(MIN_HOLD));
  assign gap_end   = (gap_cnt_q == GAP_W'(GAP_CYC - 1));

  always_comb begin
    higher_req = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (j < int'(owner_q) && req[j]) higher_req = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    gnt_d      = gnt_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (req != '0) begin
          state_d    = ST_PLAY;
          owner_d    = first_req;
          hold_cnt_d = '0;
          gnt_d      = NREQ'(1) << first_req;
        end
      end
      ST_PLAY: begin
        if (!hold_sat) hold_cnt_d = hold_cnt_q + 1'b1;
        // Release and preemption in the same cycle collapse into one gap.
        if (!req[owner_q] || (hold_sat && higher_req)) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          gnt_d     = '0;
        end
      end
      ST_GAP: begin
        gnt_d     = '0;
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_end) begin
          gap_cnt_d = '0;
          if (req != '0) begin
            state_d    = ST_PLAY;
            owner_d    = first_req;
            hold_cnt_d = '0;
            gnt_d      = NREQ'(1) << first_req;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
    end
  end

  // Driving the divider from next-state lets the speaker flop clear on the first gap cycle.
  tone_divider #(
    .DIV_W (DIV_W)
  ) u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_d == ST_PLAY),
    .div     (div_arr[owner_d]),
    .speaker (speaker)
  );

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_speaker_arbiter.sv
// Directed scoreboard bench for speaker_arbiter with short hold and gap times.
module tb_speaker_arbiter;

  localparam int NREQ     = 4;
  localparam int DIV_W    = 15;
  localparam int MIN_HOLD = 8;
  localparam int GAP_CYC  = 4;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic       busy;
    logic       spk;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*DIV_W-1:0] div;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  speaker;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  speaker_arbiter #(
    .NREQ     (NREQ),
    .DIV_W    (DIV_W),
    .MIN_HOLD (MIN_HOLD),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .div     (div),
    .gnt     (gnt),
    .busy    (busy),
    .speaker (speaker)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected speaker level m cycles after entering PLAY with a constant nonzero divider.
  function automatic logic exp_spk(input int m, input int d);
    return 1'(((m / (d + 1)) % 2));
  endfunction

  task automatic applyStimulus(input logic [3:0] r, input int d0, input int d1,
                               input int d2, input int d3);
    req = r;
    div[0*DIV_W +: DIV_W] = DIV_W'(d0);
    div[1*DIV_W +: DIV_W] = DIV_W'(d1);
    div[2*DIV_W +: DIV_W] = DIV_W'(d2);
    div[3*DIV_W +: DIV_W] = DIV_W'(d3);
  endtask

  task automatic push_exp(input string tag, input logic [3:0] g, input logic b,
                          input logic s);
    exp_t e;
    e.tag  = tag;
    e.gnt  = g;
    e.busy = b;
    e.spk  = s;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      assert (gnt === e.gnt) else begin
        n_err++;
        $error("[TB] FAIL %s gnt: observed %b expected %b", e.tag, gnt, e.gnt);
      end
      n_vec++;
      assert (busy === e.busy) else begin
        n_err++;
        $error("[TB] FAIL %s busy: observed %b expected %b", e.tag, busy, e.busy);
      end
      n_vec++;
      assert (speaker === e.spk) else begin
        n_err++;
        $error("[TB] FAIL %s speaker: observed %b expected %b", e.tag, speaker, e.spk);
      end
    end
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic b,
                      input logic s);
    push_exp(tag, g, b, s);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    push_exp("reset", 4'b0000, 1'b0, 1'b0);
    checkOutput();
    rst_n = 1'b1;

    $display("[TB] single owner, divider 3");
    applyStimulus(4'b0100, 0, 0, 3, 0);
    for (int k = 1; k <= 13; k++) step("tone_d3", 4'b0100, 1'b1, exp_spk(k - 1, 3));

    $display("[TB] async reset while playing");
    #2 rst_n = 1'b0;
    #1;
    push_exp("async_rst", 4'b0000, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(4'b0000, 0, 0, 3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step("idle_after_rst", 4'b0000, 1'b0, 1'b0);

    $display("[TB] preemption after minimum hold");
    applyStimulus(4'b0100, 5, 0, 3, 2);
    for (int k = 1; k <= 3; k++) step("pre_hold", 4'b0100, 1'b1, exp_spk(k - 1, 3));
    applyStimulus(4'b0101, 5, 0, 3, 2);
    for (int k = 4; k <= 9; k++) step("hold_block", 4'b0100, 1'b1, exp_spk(k - 1, 3));
    for (int g = 0; g < GAP_CYC; g++) step("preempt_gap", 4'b0000, 1'b1, 1'b0);
    step("grant0", 4'b0001, 1'b1, 1'b0);

    $display("[TB] lower priority never preempts");
    applyStimulus(4'b1001, 5, 0, 3, 2);
    for (int m = 1; m <= 14; m++) step("no_preempt", 4'b0001, 1'b1, exp_spk(m, 5));
    applyStimulus(4'b1000, 5, 0, 3, 2);
    for (int g = 0; g < GAP_CYC; g++) step("release_gap", 4'b0000, 1'b1, 1'b0);
    for (int m = 0; m <= 6; m++) step("grant3", 4'b1000, 1'b1, exp_spk(m, 2));

    rst_n = 1'b0;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] divider sweep and mute");
    applyStimulus(4'b0010, 0, 3, 0, 0);
    for (int m = 0; m <= 5; m++) step("sweep_d3", 4'b0010, 1'b1, exp_spk(m, 3));
    applyStimulus(4'b0010, 0, 7, 0, 0);
    for (int m = 6; m <= 16; m++)
      step("sweep_d7", 4'b0010, 1'b1, (m <= 7) || (m == 16));
    applyStimulus(4'b0010, 0, 0, 0, 0);
    for (int m = 17; m <= 20; m++) step("mute", 4'b0010, 1'b1, 1'b0);

    $display("[TB] release to idle, transient request in gap");
    applyStimulus(4'b0000, 0, 0, 0, 0);
    step("idle_gap", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0100, 0, 0, 3, 0);
    step("idle_gap", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 0, 0, 3, 0);
    step("idle_gap", 4'b0000, 1'b1, 1'b0);
    step("idle_gap", 4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step("back_idle", 4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
